// File: rtl/ret_stack_commit.sv
// Committed (retire-side) return stack for two threads.
// Tracks committed calls/returns per thread in a circular array. After an
// exception, it replays the surviving entries oldest-first into the fetch
// return stack's push port. A shared FSM serves one thread at a time.
module ret_stack_commit #(
  parameter int DATA_WIDTH = 67,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmt_call,
  input  logic                  cmt_ret,
  input  logic                  cmt_thread,
  input  logic [DATA_WIDTH-1:0] cmt_data,
  input  logic                  except,
  input  logic                  except_thread,
  output logic                  repl_wen,
  output logic                  repl_thread,
  output logic [DATA_WIDTH-1:0] repl_data,
  output logic [4:0]            repl_lnk,
  output logic [1:0]            repl_busy,
  output logic                  repl_done
);

  typedef enum logic [1:0] {S_IDLE, S_REPLAY, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  // Storage (not reset: contents are only meaningful below cnt)
  logic [DATA_WIDTH-1:0] ram_q [2][DEPTH];

  // Per-thread pointers
  logic [ADDR_WIDTH-1:0] wptr_q [2];
  logic [ADDR_WIDTH-1:0] wptr_d [2];
  logic [ADDR_WIDTH:0]   cnt_q  [2];
  logic [ADDR_WIDTH:0]   cnt_d  [2];
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;

  // Replay FSM state
  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [1:0]            pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;

  // Registered outputs
  logic                  wen_q, wen_d;
  logic                  thr_q, thr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [4:0]            lnk_q, lnk_d;
  logic [1:0]            busy_q, busy_d;
  logic                  done_q, done_d;

  // Thread 0 wins when both threads have a pending replay
  logic                  pick;
  logic [ADDR_WIDTH-1:0] oldest_pick;

  assign pick        = ~pend_q[0];
  assign oldest_pick = wptr_q[pick] - cnt_q[pick][ADDR_WIDTH-1:0];

  // Commit decode: a thread under replay ignores its commits
  always_comb begin
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = wptr_q[cmt_thread];
    if (!busy_q[cmt_thread]) begin
      if (cmt_call && cmt_ret && (cnt_q[cmt_thread] != '0)) begin
        // Return then call: the top entry is replaced in place
        ram_we    = 1'b1;
        ram_waddr = wptr_q[cmt_thread] - PTR_ONE;
      end else if (cmt_call) begin
        // When full the write lands on the oldest slot, which is dropped
        ram_we               = 1'b1;
        wptr_d[cmt_thread]   = wptr_q[cmt_thread] + PTR_ONE;
        if (cnt_q[cmt_thread] != CNT_FULL)
          cnt_d[cmt_thread]  = cnt_q[cmt_thread] + CNT_ONE;
      end else if (cmt_ret && (cnt_q[cmt_thread] != '0)) begin
        wptr_d[cmt_thread] = wptr_q[cmt_thread] - PTR_ONE;
        cnt_d[cmt_thread]  = cnt_q[cmt_thread] - CNT_ONE;
      end
    end
  end

  // Entry write port
  always_ff @(posedge clk) begin
    if (ram_we)
      ram_q[cmt_thread][ram_waddr] <= cmt_data;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '{default: '0};
      cnt_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Replay sequencing; outputs are computed for the cycle after the edge
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    ridx_d  = ridx_q;
    rem_d   = rem_q;
    wen_d   = 1'b0;
    data_d  = '0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          sel_d        = pick;
          pend_d[pick] = 1'b0;
          if (cnt_q[pick] != '0) begin
            // First push leaves on the same edge as the selection
            wen_d   = 1'b1;
            data_d  = ram_q[pick][oldest_pick];
            ridx_d  = oldest_pick + PTR_ONE;
            rem_d   = cnt_q[pick] - CNT_ONE;
            state_d = S_REPLAY;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REPLAY: begin
        if (except && (except_thread == sel_q)) begin
          // Fetch stack was emptied again: abort, restart via pend
          state_d = S_IDLE;
        end else if (rem_q != '0) begin
          wen_d  = 1'b1;
          data_d = ram_q[sel_q][ridx_q];
          ridx_d = ridx_q + PTR_ONE;
          rem_d  = rem_q - CNT_ONE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (except)
      pend_d[except_thread] = 1'b1;
    busy_d = pend_d;
    if (state_d != S_IDLE)
      busy_d[sel_d] = 1'b1;
    thr_d = wen_d & sel_d;
    lnk_d = {1'b0, data_d[3:0]};
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      pend_q  <= 2'b00;
      ridx_q  <= '0;
      rem_q   <= '0;
      wen_q   <= 1'b0;
      thr_q   <= 1'b0;
      data_q  <= '0;
      lnk_q   <= '0;
      busy_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      ridx_q  <= ridx_d;
      rem_q   <= rem_d;
      wen_q   <= wen_d;
      thr_q   <= thr_d;
      data_q  <= data_d;
      lnk_q   <= lnk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign repl_wen    = wen_q;
  assign repl_thread = thr_q;
  assign repl_data   = data_q;
  assign repl_lnk    = lnk_q;
  assign repl_busy   = busy_q;
  assign repl_done   = done_q;

endmodule

// File: tb/tb_ret_stack_commit.sv
// Bench for ret_stack_commit: queue-based reference stacks per thread,
// scoreboard of expected replay pushes, table of replay scenarios plus
// hand-written multi-cycle sequences.
module tb_ret_stack_commit;

  logic        clk = 1'b0;
  logic        rst, cmt_call, cmt_ret, cmt_thread, except, except_thread;
  logic [66:0] cmt_data;
  logic        repl_wen, repl_thread, repl_done;
  logic [66:0] repl_data;
  logic [4:0]  repl_lnk;
  logic [1:0]  repl_busy;

  always #5 clk = ~clk;

  ret_stack_commit #(.DATA_WIDTH(67), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmt_call(cmt_call), .cmt_ret(cmt_ret), .cmt_thread(cmt_thread),
    .cmt_data(cmt_data),
    .except(except), .except_thread(except_thread),
    .repl_wen(repl_wen), .repl_thread(repl_thread), .repl_data(repl_data),
    .repl_lnk(repl_lnk), .repl_busy(repl_busy), .repl_done(repl_done)
  );

  typedef struct packed { logic thr; logic [66:0] data; } exp_t;
  typedef struct { logic thr; int npush; int nret; int exp_n; } row_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [66:0] mstk0[$], mstk1[$], tmp[$];
  row_t        rows[6];

  int total = 0, bad = 0;
  int cyc = 0, push_cnt = 0, done_cnt = 0, done_cyc = 0, first_wen = -1, t_exc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every push must match the next expected entry
  always @(negedge clk) begin
    if (repl_wen) begin
      push_cnt++;
      if (first_wen < 0) first_wen = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_push", {repl_thread, repl_data}, 0);
      end else begin
        e = sbq.pop_front();
        chk("push_data", repl_data, e.data);
        chk("push_thread", repl_thread, e.thr);
        chk("push_lnk", repl_lnk, {1'b0, e.data[3:0]});
      end
    end
    if (repl_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [66:0] rnd();
    rnd = {3'($urandom_range(7)), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    sbq.delete();
    mstk0.delete();
    mstk1.delete();
    rst = 1'b1;
  endtask

  task automatic commit(input logic c, input logic r, input logic th,
                        input logic [66:0] d, input bit apply);
    cmt_call = c; cmt_ret = r; cmt_thread = th; cmt_data = d;
    if (apply) begin
      tmp = th ? mstk1 : mstk0;
      if (c && r) begin
        if (tmp.size() > 0) tmp[tmp.size()-1] = d;
        else tmp.push_back(d);
      end else if (c) begin
        if (tmp.size() == 16) void'(tmp.pop_front());
        tmp.push_back(d);
      end else if (r) begin
        if (tmp.size() > 0) void'(tmp.pop_back());
      end
      if (th) mstk1 = tmp; else mstk0 = tmp;
    end
    step();
    cmt_call = 1'b0; cmt_ret = 1'b0; cmt_thread = 1'b0; cmt_data = '0;
  endtask

  task automatic do_except(input logic th);
    tmp = th ? mstk1 : mstk0;
    foreach (tmp[i]) sbq.push_back({th, tmp[i]});
    t_exc = cyc;
    first_wen = -1;
    except = 1'b1; except_thread = th;
    step();
    except = 1'b0; except_thread = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 60 && done_cnt < target; i++) step();
    chk(name, done_cnt >= target, 1);
  endtask

  initial begin
    int p0, d0, t0;
    #2000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p0, d0, t0, t_ab;
    logic [66:0] a, b, c;
    rows[0] = '{1'b0, 3, 0, 3};
    rows[1] = '{1'b0, 18, 0, 16};
    rows[2] = '{1'b1, 0, 0, 0};
    rows[3] = '{1'b1, 5, 2, 3};
    rows[4] = '{1'b0, 2, 5, 0};
    rows[5] = '{1'b1, 16, 1, 15};

    rst = 1'b0; cmt_call = 0; cmt_ret = 0; cmt_thread = 0; cmt_data = '0;
    except = 0; except_thread = 0;
    do_reset();
    chk("reset_outputs", {repl_wen, repl_thread, repl_done, repl_busy, repl_lnk, repl_data}, 0);

    // Replay scenarios from the table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < rows[i].npush; k++) commit(1, 0, rows[i].thr, rnd(), 1);
      for (int k = 0; k < rows[i].nret; k++) commit(0, 1, rows[i].thr, '0, 1);
      p0 = push_cnt; d0 = done_cnt;
      do_except(rows[i].thr);
      wait_done(d0 + 1, "row_done_seen");
      chk("row_pushes", push_cnt - p0, rows[i].exp_n);
      chk("row_done_lat", done_cyc - t_exc, rows[i].exp_n + 2);
      if (rows[i].exp_n > 0) chk("row_first_lat", first_wen - t_exc, 2);
      chk("row_sb_empty", sbq.size(), 0);
    end

    // Underflow and call+ret replacement: only C survives
    do_reset();
    a = rnd(); b = rnd(); c = rnd();
    commit(1, 0, 0, a, 1);
    commit(0, 1, 0, '0, 1);
    commit(0, 1, 0, '0, 1);
    commit(1, 0, 0, b, 1);
    commit(1, 1, 0, c, 1);
    p0 = push_cnt; d0 = done_cnt;
    do_except(0);
    wait_done(d0 + 1, "cr_done_seen");
    chk("cr_pushes", push_cnt - p0, 1);
    chk("cr_sb_empty", sbq.size(), 0);

    // Empty replay: busy window and done timing
    do_reset();
    d0 = done_cnt;
    do_except(1);
    chk("empty_busy_t1", repl_busy, 2'b10);
    chk("empty_nodone_t1", repl_done, 0);
    step();
    chk("empty_done_t2", {repl_done, repl_wen}, 2'b10);
    chk("empty_busy_t2", repl_busy, 2'b10);
    step();
    chk("empty_idle_t3", {repl_busy, repl_done}, 0);

    // Cross-thread except during replay; commits during/after busy
    do_reset();
    for (int k = 0; k < 8; k++) commit(1, 0, 0, rnd(), 1);
    for (int k = 0; k < 3; k++) commit(1, 0, 1, rnd(), 1);
    p0 = push_cnt; d0 = done_cnt;
    do_except(0);
    t0 = t_exc;
    step();
    step();
    do_except(1);
    wait_done(d0 + 1, "x_t0_done_seen");
    chk("x_t0_done_lat", done_cyc - t0, 10);
    chk("x_busy_after_t0", repl_busy, 2'b10);
    commit(1, 0, 1, rnd(), 0);
    commit(1, 0, 0, rnd(), 1);
    wait_done(d0 + 2, "x_t1_done_seen");
    chk("x_pushes", push_cnt - p0, 11);
    chk("x_sb_empty", sbq.size(), 0);
    do_except(1);
    wait_done(d0 + 3, "x_t1b_done_seen");
    do_except(0);
    wait_done(d0 + 4, "x_t0b_done_seen");
    chk("x_pushes_total", push_cnt - p0, 11 + 3 + 9);
    chk("x_sb_empty2", sbq.size(), 0);

    // Same-thread except at the 4th push restarts from the oldest
    do_reset();
    for (int k = 0; k < 8; k++) commit(1, 0, 0, rnd(), 1);
    p0 = push_cnt; d0 = done_cnt;
    do_except(0);
    for (int k = 0; k < 4; k++) step();
    t_ab = cyc;
    except = 1'b1; except_thread = 1'b0;
    step();
    except = 1'b0;
    chk("ab_popped", push_cnt - p0, 4);
    chk("ab_wen_low", repl_wen, 0);
    chk("ab_busy", repl_busy, 2'b01);
    sbq.delete();
    foreach (mstk0[i]) sbq.push_back({1'b0, mstk0[i]});
    wait_done(d0 + 1, "ab_done_seen");
    chk("ab_done_lat", done_cyc - t_ab, 10);
    chk("ab_single_done", done_cnt, d0 + 1);
    chk("ab_sb_empty", sbq.size(), 0);

    // Reset in the middle of a replay
    do_except(0);
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("midrst_outputs", {repl_wen, repl_thread, repl_done, repl_busy, repl_lnk, repl_data}, 0);
    sbq.delete();
    mstk0.delete();
    mstk1.delete();
    rst = 1'b1;
    d0 = done_cnt; p0 = push_cnt;
    for (int k = 0; k < 15; k++) step();
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_no_push", push_cnt, p0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
